// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over
// back-to-back windows of GATE_CYCLES clk cycles and publishes edges*SCALE in Hz.
module freq_meter #(
   parameter int GATE_CYCLES = 5_000_000,
   parameter int SCALE       = 10,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sig_in,
   input  logic                  hold,
   output logic [DATA_WIDTH-1:0] freq_out,
   output logic                  freq_valid,
   output logic                  overflow
);

   localparam int GW = $clog2(GATE_CYCLES + 1);
   localparam int PW = DATA_WIDTH + 32;
   localparam logic [GW-1:0]         GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [DATA_WIDTH-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {ARM, GATE, DONE} state_t;

   state_t                state, state_nxt;
   logic                  sync_d, sync_q, sync_qq;
   logic [2:0]            vld_pipe;
   logic                  edge_p;
   logic [GW-1:0]         gate_cnt;
   logic                  gate_done;
   logic [DATA_WIDTH-1:0] edge_cnt;
   logic                  cnt_sat;
   logic [PW-1:0]         prod;
   logic                  prod_sat;
   logic [DATA_WIDTH-1:0] result;
   logic                  overflow_next;

   // vld_pipe masks the detector until sync_qq holds a real sample, so a
   // signal already high at reset release is not mistaken for an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_d   <= 1'b0;
         sync_q   <= 1'b0;
         sync_qq  <= 1'b0;
         vld_pipe <= '0;
      end else begin
         sync_d   <= sig_in;
         sync_q   <= sync_d;
         sync_qq  <= sync_q;
         vld_pipe <= {vld_pipe[1:0], 1'b1};
      end
   end

   assign edge_p    = sync_q & ~sync_qq & vld_pipe[2];
   assign gate_done = (gate_cnt == GATE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ARM;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARM:     if (edge_p) state_nxt = GATE;
                  else if (gate_done) state_nxt = DONE;
         GATE:    if (gate_done) state_nxt = DONE;
         DONE:    state_nxt = GATE;
         default: state_nxt = ARM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         cnt_sat  <= 1'b0;
      end else begin
         case (state)
            ARM: begin
               gate_cnt <= (state_nxt == ARM) ? gate_cnt + 1'b1 : '0;
               edge_cnt <= '0;
               cnt_sat  <= 1'b0;
            end
            GATE: begin
               gate_cnt <= (state_nxt == GATE) ? gate_cnt + 1'b1 : '0;
               if (edge_p) begin
                  if (edge_cnt == CNT_MAX) cnt_sat  <= 1'b1;
                  else                     edge_cnt <= edge_cnt + 1'b1;
               end
            end
            default: begin
               // An edge landing in DONE belongs to the window starting now
               gate_cnt <= '0;
               edge_cnt <= {{(DATA_WIDTH-1){1'b0}}, edge_p};
               cnt_sat  <= 1'b0;
            end
         endcase
      end
   end

   assign prod          = PW'(edge_cnt) * PW'(SCALE);
   assign prod_sat      = (prod > PW'(CNT_MAX));
   assign result        = prod_sat ? CNT_MAX : prod[DATA_WIDTH-1:0];
   assign overflow_next = prod_sat | cnt_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freq_out   <= '0;
         freq_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         freq_valid <= (state == DONE) && !hold;
         if (state == DONE && !hold) begin
            freq_out <= result;
            overflow <= overflow_next;
         end
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: 32-bit and 8-bit instances share stimulus;
// expected results come from period-based arithmetic pushed as stimulus changes.
module tb_freq_meter;

   localparam int G  = 1000;
   localparam int SC = 10;

   typedef struct {
      bit skip;
      int lo;
      int hi;
      int ovf;   // 0/1 expected, 2 = don't care
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sig_in = 1'b0;
   logic        hold = 1'b0;
   logic [31:0] fo32;
   logic        fv32, ov32;
   logic [7:0]  fo8;
   logic        fv8, ov8;

   exp_t q32[$];
   exp_t q8[$];
   int   n_chk = 0, n_fail = 0;
   int   cyc = 0;
   int   period = 0;
   bit   dc_level = 1'b0;
   int   n32 = 0, n8 = 0;
   int   last_v = 0, prev_v = 0, first_v = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   freq_meter #(.GATE_CYCLES(G), .SCALE(SC), .DATA_WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .hold(hold),
      .freq_out(fo32), .freq_valid(fv32), .overflow(ov32));

   freq_meter #(.GATE_CYCLES(G), .SCALE(SC), .DATA_WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .hold(hold),
      .freq_out(fo8), .freq_valid(fv8), .overflow(ov8));

   task automatic chk(input string nm, input bit ok, input longint act,
                      input longint lo, input longint hi);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
      end
   endtask

   task automatic cmp(input string nm, input exp_t e, input longint f, input bit o);
      if (!e.skip) begin
         chk({nm, "_freq"}, f >= e.lo && f <= e.hi, f, e.lo, e.hi);
         if (e.ovf != 2) chk({nm, "_ovf"}, o == e.ovf[0], o, e.ovf, e.ovf);
      end
   endtask

   // Reference model: the 32-bit instance sees the raw range, the 8-bit
   // instance the same range clipped to 255 with overflow when clipping is certain.
   task automatic push(input int lo, input int hi, input bit skip);
      exp_t e;
      e.skip = skip; e.lo = lo; e.hi = hi; e.ovf = 0;
      q32.push_back(e);
      if (lo > 255) begin e.lo = 255; e.hi = 255; e.ovf = 1; end
      else if (hi > 255) begin e.hi = 255; e.ovf = 2; end
      q8.push_back(e);
   endtask

   // A square wave of period p gives G/p edges per gate, +/- one edge of phase.
   task automatic push_p(input int p);
      int f;
      f = G * SC / p;
      push(f - SC, f + SC, 1'b0);
   endtask

   task automatic wait_n(input int target, input int budget);
      int t;
      t = 0;
      while (n32 < target && t < budget) begin
         @(posedge clk); #1;
         t++;
      end
      chk("wait_valid", n32 >= target, n32, target, target);
   endtask

   initial begin
      int ph, pp;
      ph = 0; pp = 0;
      forever begin
         @(negedge clk);
         if (period != pp) begin pp = period; ph = 0; end
         if (period == 0) sig_in = dc_level;
         else if (ph >= period / 2 - 1) begin sig_in = ~sig_in; ph = 0; end
         else ph++;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (fv32) begin
         n32++;
         prev_v = last_v;
         last_v = cyc;
         if (first_v < 0) first_v = cyc;
         if (q32.size() == 0) chk("valid32_unexpected", 1'b0, 1, 0, 0);
         else begin e = q32.pop_front(); cmp("dut32", e, longint'(fo32), ov32); end
      end
      if (fv8) begin
         n8++;
         if (q8.size() == 0) chk("valid8_unexpected", 1'b0, 1, 0, 0);
         else begin e = q8.pop_front(); cmp("dut8", e, longint'(fo8), ov8); end
      end
   end

   initial begin
      int rel, v;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_freq32", fo32 == 0, fo32, 0, 0);
      chk("reset_valid32", fv32 == 0, fv32, 0, 0);
      chk("reset_ovf32", ov32 == 0, ov32, 0, 0);
      chk("reset_freq8", fo8 == 0, fo8, 0, 0);

      // DC low from reset: timeout windows report 0 at a fixed cadence
      @(negedge clk);
      rst_n = 1'b1; rel = cyc; first_v = -1;
      repeat (3) push(0, 0, 1'b0);
      wait_n(3, 4 * G);
      chk("dc_first_latency", first_v - rel >= G && first_v - rel <= G + 2, first_v - rel, G, G + 2);
      chk("dc_interval", last_v - prev_v == G + 1, last_v - prev_v, G + 1, G + 1);

      // Single edge whose pulse lands on the DONE cycle goes to the next window
      v = last_v;
      push(0, 0, 1'b0); push(SC, SC, 1'b0); push(0, 0, 1'b0);
      while (cyc != v + G - 2) begin @(posedge clk); #1; end
      dc_level = 1'b1;
      wait_n(6, 4 * G);

      // Period 20 -> 500 Hz
      period = 20;
      push_p(20); push_p(20);
      wait_n(8, 4 * G);

      // Hold across a DONE while the period changes to 40
      hold = 1'b1; period = 40;
      repeat (2 * (G + 1) + 500) @(posedge clk);
      #1;
      chk("hold_no_valid", n32 == 8, n32, 8, 8);
      chk("hold_freq32", fo32 >= 490 && fo32 <= 510, fo32, 490, 510);
      chk("hold_ovf32", ov32 == 0, ov32, 0, 0);
      chk("hold_freq8", fo8 == 255, fo8, 255, 255);
      chk("hold_ovf8", ov8 == 1, ov8, 1, 1);
      hold = 1'b0;
      push_p(40);
      wait_n(9, 2 * G + 100);

      // Period 400; first window mixes old and new waveforms
      period = 400;
      push(0, 0, 1'b1); push_p(400); push_p(400);
      wait_n(12, 5 * G);

      // Reset mid-gate discards the partial window
      period = 20;
      repeat (500) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset_freq32", fo32 == 0, fo32, 0, 0);
      chk("midreset_ovf8", ov8 == 0, ov8, 0, 0);
      chk("midreset_freq8", fo8 == 0, fo8, 0, 0);
      chk("midreset_valid", (fv32 | fv8) == 0, fv32 | fv8, 0, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1; rel = cyc; first_v = -1;
      push_p(20); push_p(20);
      wait_n(14, 4 * G);
      chk("post_reset_latency", first_v - rel >= G + 1 && first_v - rel <= G + 60, first_v - rel, G + 1, G + 60);
      chk("dut8_valid_count", n8 == n32, n8, n32, n32);
      chk("queues_drained", q32.size() == 0 && q8.size() == 0, q32.size() + q8.size(), 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
